// File: rtl/gfifo_step_batcher.sv
// rtl/gfifo_step_batcher.sv - batches multi-channel difftest step counts towards the host gfifo
//
// Sums per-cycle step counts from N_CH channels into a saturating accumulator.
// Batches are flushed to the host on a threshold or idle timeout.
// The host is polled for a simulation result at a fixed interval.
// A reported result freezes all further step traffic.
//
// Ports:
//   clock, reset   clock and asynchronous active-low reset
//   step           N_CH packed step counts, channel i at [i*STEP_WIDTH +: STEP_WIDTH]
//   flush_valid    batch presented (held until flush_ready)
//   flush_ready    host accepts the batch
//   flush_step     batched step count, stable while flush_valid
//   fetch_req      result poll request, held until fetch_ack
//   fetch_ack      poll completed, fetch_result valid
//   fetch_result   host completion flag sampled on fetch_ack
//   simv_result    sticky host completion
//   overflow       sticky accumulator saturation
module gfifo_step_batcher #(
  parameter int N_CH            = 1,
  parameter int STEP_WIDTH      = 8,
  parameter int ACC_WIDTH       = 16,
  parameter int BATCH_THRESHOLD = 1,
  parameter int BATCH_TIMEOUT   = 0,
  parameter int FETCH_INTERVAL  = 4999
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CH*STEP_WIDTH-1:0] step,
  output logic                       flush_valid,
  input  logic                       flush_ready,
  output logic [ACC_WIDTH-1:0]       flush_step,
  output logic                       fetch_req,
  input  logic                       fetch_ack,
  input  logic                       fetch_result,
  output logic                       simv_result,
  output logic                       overflow
);

  localparam int SUM_W  = STEP_WIDTH + $clog2(N_CH + 1);
  localparam int EXT_W  = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
  localparam int IDLE_W = (BATCH_TIMEOUT > 0) ? $clog2(BATCH_TIMEOUT + 1) : 1;
  localparam int FT_W   = (FETCH_INTERVAL > 0) ? $clog2(FETCH_INTERVAL + 1) : 1;

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_flush_step;
  logic                 r_flush_valid;
  logic [IDLE_W-1:0]    r_idle;
  logic [FT_W-1:0]      r_ftimer;
  logic                 r_fetch_req;
  logic                 r_simv;
  logic                 r_overflow;

  logic [SUM_W-1:0]     w_sum;
  logic [ACC_WIDTH-1:0] w_base;
  logic [EXT_W-1:0]     w_ext;
  logic                 w_sat;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_flush_cond;
  logic                 w_stop;
  logic                 w_handshake;
  logic                 w_load;

  // Channel sum; steps are dropped entirely once the host has finished.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_sum = w_sum + SUM_W'(step[i*STEP_WIDTH +: STEP_WIDTH]);
    end
    if (r_simv) begin
      w_sum = '0;
    end
  end

  // Flush decision looks at the registered accumulator only.
  assign w_flush_cond = (r_acc >= ACC_WIDTH'(BATCH_THRESHOLD)) ||
                        ((BATCH_TIMEOUT != 0) && (r_acc != '0) &&
                         (r_idle == IDLE_W'(BATCH_TIMEOUT)));

  // A result arriving this edge must already block a reload on the same edge.
  assign w_stop      = r_simv | (r_fetch_req & fetch_ack & fetch_result);
  assign w_handshake = r_flush_valid & flush_ready;
  assign w_load      = w_flush_cond & ~w_stop &
                       ((r_state == S_IDLE) | w_handshake);

  // On a load the old contents leave as the batch, so saturation only sees the new sum.
  assign w_base     = w_load ? '0 : r_acc;
  assign w_ext      = EXT_W'(w_base) + EXT_W'(w_sum);
  assign w_sat      = |w_ext[EXT_W-1:ACC_WIDTH];
  assign w_acc_next = w_sat ? '1 : w_ext[ACC_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_flush_step  <= '0;
      r_flush_valid <= 1'b0;
      r_idle        <= '0;
      r_ftimer      <= '0;
      r_fetch_req   <= 1'b0;
      r_simv        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      // Accumulator and idle timer freeze once the result is in.
      if (!r_simv) begin
        r_acc <= w_acc_next;
        if (w_sat) begin
          r_overflow <= 1'b1;
        end
        if ((r_acc == '0) || w_load) begin
          r_idle <= '0;
        end else if (r_idle != IDLE_W'(BATCH_TIMEOUT)) begin
          r_idle <= r_idle + IDLE_W'(1);
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_flush_step  <= r_acc;
            r_flush_valid <= 1'b1;
            r_state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (w_handshake) begin
            if (w_load) begin
              r_flush_step <= r_acc;
            end else begin
              r_flush_valid <= 1'b0;
              r_state       <= S_IDLE;
            end
          end
        end
        default: begin
          r_flush_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase

      // Poll timer runs only while no poll is outstanding.
      if (r_fetch_req) begin
        if (fetch_ack) begin
          r_fetch_req <= 1'b0;
          if (fetch_result) begin
            r_simv <= 1'b1;
          end
        end
      end else if (!r_simv) begin
        if (r_ftimer == FT_W'(FETCH_INTERVAL)) begin
          r_fetch_req <= 1'b1;
          r_ftimer    <= '0;
        end else begin
          r_ftimer <= r_ftimer + FT_W'(1);
        end
      end
    end
  end

  assign flush_valid = r_flush_valid;
  assign flush_step  = r_flush_step;
  assign fetch_req   = r_fetch_req;
  assign simv_result = r_simv;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_gfifo_step_batcher.sv
// tb/tb_gfifo_step_batcher.sv - directed self-checking bench for gfifo_step_batcher
module tb_gfifo_step_batcher;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // a: 2 channels, threshold 10
  logic [15:0] st_a;  logic rdy_a;  logic fv_a;  logic [15:0] fs_a;  logic fr_a, sr_a, ov_a;
  // b: threshold 100, timeout 5
  logic [7:0]  st_b;  logic rdy_b;  logic fv_b;  logic [15:0] fs_b;  logic fr_b, sr_b, ov_b;
  // c: threshold 4
  logic [7:0]  st_c;  logic rdy_c;  logic fv_c;  logic [15:0] fs_c;  logic fr_c, sr_c, ov_c;
  // d: fetch interval 9, threshold 1
  logic [7:0]  st_d;  logic rdy_d;  logic fv_d;  logic [15:0] fs_d;  logic fr_d, sr_d, ov_d;
  logic        ack_d, res_d;
  // e: 8-bit accumulator, threshold 255
  logic [7:0]  st_e;  logic rdy_e;  logic fv_e;  logic [7:0]  fs_e;  logic fr_e, sr_e, ov_e;

  gfifo_step_batcher #(.N_CH(2), .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_THRESHOLD(10),
                       .BATCH_TIMEOUT(0), .FETCH_INTERVAL(4999)) u_a (
    .clock(clock), .reset(reset), .step(st_a), .flush_valid(fv_a), .flush_ready(rdy_a),
    .flush_step(fs_a), .fetch_req(fr_a), .fetch_ack(1'b0), .fetch_result(1'b0),
    .simv_result(sr_a), .overflow(ov_a));

  gfifo_step_batcher #(.N_CH(1), .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_THRESHOLD(100),
                       .BATCH_TIMEOUT(5), .FETCH_INTERVAL(4999)) u_b (
    .clock(clock), .reset(reset), .step(st_b), .flush_valid(fv_b), .flush_ready(rdy_b),
    .flush_step(fs_b), .fetch_req(fr_b), .fetch_ack(1'b0), .fetch_result(1'b0),
    .simv_result(sr_b), .overflow(ov_b));

  gfifo_step_batcher #(.N_CH(1), .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_THRESHOLD(4),
                       .BATCH_TIMEOUT(0), .FETCH_INTERVAL(4999)) u_c (
    .clock(clock), .reset(reset), .step(st_c), .flush_valid(fv_c), .flush_ready(rdy_c),
    .flush_step(fs_c), .fetch_req(fr_c), .fetch_ack(1'b0), .fetch_result(1'b0),
    .simv_result(sr_c), .overflow(ov_c));

  gfifo_step_batcher #(.N_CH(1), .STEP_WIDTH(8), .ACC_WIDTH(16), .BATCH_THRESHOLD(1),
                       .BATCH_TIMEOUT(0), .FETCH_INTERVAL(9)) u_d (
    .clock(clock), .reset(reset), .step(st_d), .flush_valid(fv_d), .flush_ready(rdy_d),
    .flush_step(fs_d), .fetch_req(fr_d), .fetch_ack(ack_d), .fetch_result(res_d),
    .simv_result(sr_d), .overflow(ov_d));

  gfifo_step_batcher #(.N_CH(1), .STEP_WIDTH(8), .ACC_WIDTH(8), .BATCH_THRESHOLD(255),
                       .BATCH_TIMEOUT(0), .FETCH_INTERVAL(4999)) u_e (
    .clock(clock), .reset(reset), .step(st_e), .flush_valid(fv_e), .flush_ready(rdy_e),
    .flush_step(fs_e), .fetch_req(fr_e), .fetch_ack(1'b0), .fetch_result(1'b0),
    .simv_result(sr_e), .overflow(ov_e));

  typedef struct {
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic        rdy;
    logic        ev;
    logic [15:0] es;
  } vec_t;

  vec_t tv[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    st_a = '0; rdy_a = 1'b0; st_b = '0; rdy_b = 1'b0; st_c = '0; rdy_c = 1'b0;
    st_d = '0; rdy_d = 1'b0; ack_d = 1'b0; res_d = 1'b0; st_e = '0; rdy_e = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int seen;
    clear_inputs();

    //               s0   s1   rdy  ev   es
    tv[0]  = '{8'd3,   8'd4,   1'b1, 1'b0, 16'd0};
    tv[1]  = '{8'd3,   8'd4,   1'b1, 1'b0, 16'd0};
    tv[2]  = '{8'd0,   8'd0,   1'b1, 1'b1, 16'd14};
    tv[3]  = '{8'd1,   8'd2,   1'b1, 1'b0, 16'd14};
    tv[4]  = '{8'd5,   8'd5,   1'b0, 1'b0, 16'd14};
    tv[5]  = '{8'd0,   8'd0,   1'b0, 1'b1, 16'd13};
    tv[6]  = '{8'd4,   8'd0,   1'b0, 1'b1, 16'd13};
    tv[7]  = '{8'd6,   8'd0,   1'b0, 1'b1, 16'd13};
    tv[8]  = '{8'd0,   8'd0,   1'b1, 1'b1, 16'd10};
    tv[9]  = '{8'd0,   8'd0,   1'b1, 1'b0, 16'd10};
    tv[10] = '{8'd255, 8'd255, 1'b0, 1'b0, 16'd10};
    tv[11] = '{8'd0,   8'd0,   1'b0, 1'b1, 16'd510};
    tv[12] = '{8'd0,   8'd0,   1'b1, 1'b0, 16'd510};

    // Reset state while reset is held
    #1;
    check("rst_flush_valid", 32'(fv_a), 0);
    check("rst_flush_step",  32'(fs_a), 0);
    check("rst_fetch_req",   32'(fr_d), 0);
    check("rst_simv",        32'(sr_d), 0);
    check("rst_overflow",    32'(ov_e), 0);

    // Threshold batching, back-to-back reload and drop
    do_reset();
    for (int i = 0; i < 13; i++) begin
      st_a  = {tv[i].s1, tv[i].s0};
      rdy_a = tv[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(fv_a), 32'(tv[i].ev));
      check($sformatf("vec%0d_step", i),  32'(fs_a), 32'(tv[i].es));
    end

    // Timeout flush: acc=7 after edge 1, idle reaches 5 at edge 6, load at edge 7
    do_reset();
    st_b = 8'd7; rdy_b = 1'b1;
    tick();
    check("to_e1_valid", 32'(fv_b), 0);
    st_b = 8'd0;
    for (int k = 2; k <= 6; k++) begin
      tick();
      check($sformatf("to_e%0d_valid", k), 32'(fv_b), 0);
    end
    tick();
    check("to_e7_valid", 32'(fv_b), 1);
    check("to_e7_step",  32'(fs_b), 7);
    tick();
    check("to_e8_valid", 32'(fv_b), 0);

    // Backpressure: batch of 4 held 20 cycles, then 20 follows with no bubble
    do_reset();
    st_c = 8'd1; rdy_c = 1'b0;
    repeat (4) tick();
    check("bp_pre_valid", 32'(fv_c), 0);
    for (int k = 5; k <= 24; k++) begin
      tick();
      check($sformatf("bp_e%0d_valid", k), 32'(fv_c), 1);
      check($sformatf("bp_e%0d_step", k),  32'(fs_c), 4);
    end
    st_c = 8'd0; rdy_c = 1'b1;
    tick();
    check("bp_e25_valid", 32'(fv_c), 1);
    check("bp_e25_step",  32'(fs_c), 20);
    tick();
    check("bp_e26_valid", 32'(fv_c), 0);

    // Polling, simultaneous handshake + completing ack, and freeze afterwards
    do_reset();
    repeat (9) tick();
    check("poll_e9_req", 32'(fr_d), 0);
    tick();
    check("poll_e10_req", 32'(fr_d), 1);
    tick();
    tick();
    check("poll_e12_req", 32'(fr_d), 1);
    ack_d = 1'b1; res_d = 1'b0;
    tick();
    check("poll_e13_req",  32'(fr_d), 0);
    check("poll_e13_simv", 32'(sr_d), 0);
    ack_d = 1'b0;
    repeat (7) tick();
    st_d = 8'd3;
    tick();
    st_d = 8'd0;
    tick();
    check("poll_e22_valid", 32'(fv_d), 1);
    check("poll_e22_step",  32'(fs_d), 3);
    check("poll_e22_req",   32'(fr_d), 0);
    st_d = 8'd2;
    tick();
    check("poll_e23_req",   32'(fr_d), 1);
    check("poll_e23_valid", 32'(fv_d), 1);
    st_d = 8'd0; rdy_d = 1'b1; ack_d = 1'b1; res_d = 1'b1;
    tick();
    check("poll_e24_valid", 32'(fv_d), 0);
    check("poll_e24_simv",  32'(sr_d), 1);
    check("poll_e24_req",   32'(fr_d), 0);
    check("poll_e24_step",  32'(fs_d), 3);
    ack_d = 1'b0; res_d = 1'b0; st_d = 8'd5;
    seen = 0;
    repeat (30) begin
      tick();
      if (fv_d || fr_d) seen++;
    end
    check("frozen_activity", 32'(seen), 0);
    check("frozen_simv",     32'(sr_d), 1);

    // Saturation and sticky overflow
    do_reset();
    st_e = 8'd200; rdy_e = 1'b0;
    tick();
    check("ovf_e1_overflow", 32'(ov_e), 0);
    tick();
    check("ovf_e2_overflow", 32'(ov_e), 1);
    check("ovf_e2_valid",    32'(fv_e), 0);
    st_e = 8'd0;
    tick();
    check("ovf_e3_valid", 32'(fv_e), 1);
    check("ovf_e3_step",  32'(fs_e), 255);
    rdy_e = 1'b1;
    tick();
    check("ovf_e4_valid",    32'(fv_e), 0);
    check("ovf_e4_overflow", 32'(ov_e), 1);

    // Asynchronous reset mid-PRESENT and mid-poll
    do_reset();
    st_c = 8'd1; rdy_c = 1'b0;
    repeat (12) tick();
    check("ar_pre_valid", 32'(fv_c), 1);
    check("ar_pre_req",   32'(fr_d), 1);
    #3 reset = 1'b0;
    #1;
    check("ar_valid", 32'(fv_c), 0);
    check("ar_step",  32'(fs_c), 0);
    check("ar_req",   32'(fr_d), 0);
    st_c = 8'd0; rdy_c = 1'b1;
    #2 reset = 1'b1;
    repeat (9) tick();
    check("ar_e9_req",   32'(fr_d), 0);
    check("ar_e9_valid", 32'(fv_c), 0);
    tick();
    check("ar_e10_req", 32'(fr_d), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
